// File: rtl/aes_pkg.sv
// Shared AES decryption-datapath definitions: state width, FSM encoding and
// the InvShiftRows byte mapping used by both the serial and parallel blocks.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } inv_ss_state_t;

  // InvShiftRows moves byte (row r, column c) to column (c + r) mod 4 of the
  // same row. With k = r + 4c the column sits in k[3:2] and the row in k[1:0],
  // so the 2-bit add wraps mod 4 for free.
  function automatic logic [3:0] inv_shift_dst(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    r = k[1:0];
    c = k[3:2];
    return {c + r, r};
  endfunction

endpackage

// File: rtl/invSubBytes.sv
// Combinational AES inverse S-box: one byte in, its InvSubBytes image out.
module invSubBytes (
  input  logic [7:0] data,
  output logic [7:0] result
);

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign result = INV_SBOX[data];

endmodule

// File: rtl/inv_sub_shift_serial.sv
// Byte-serial InvShiftRows + InvSubBytes: one captured state is pushed byte by
// byte through a single inverse S-box, each result landing at its
// InvShiftRows destination, then handed downstream over valid/ready.
module inv_sub_shift_serial
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AES_STATE_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  inv_ss_state_t          state;
  inv_ss_state_t          state_next;
  logic [3:0]             cnt;
  logic [AES_STATE_W-1:0] state_q;
  logic [AES_STATE_W-1:0] out_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   accept;
  logic [7:0]             sub_in;
  logic [7:0]             sub_out;
  logic [3:0]             dst;

  assign accept    = in_valid && in_ready_q;
  assign dst       = inv_shift_dst(cnt);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

  // Pick source byte cnt out of the captured state for the shared S-box.
  always_comb begin
    sub_in = '0;
    for (int i = 0; i < AES_BYTES; i++) begin
      if (4'(i) == cnt) begin
        sub_in = state_q[AES_STATE_W-1-8*i -: 8];
      end
    end
  end

  invSubBytes u_inv_sub_bytes (
    .data   (sub_in),
    .result (sub_out)
  );

  // Next-state logic: accept in IDLE, 16 byte cycles in RUN, hold in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt == 4'd15) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus handshake flags decoded from the next state, so they
  // are registered yet line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
    end
  end

  // Capture the incoming state and step the byte counter; the counter only
  // wraps 15 -> 0 on the cycle RUN hands over to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      cnt     <= '0;
    end else if (accept) begin
      state_q <= in_data;
      cnt     <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Write each substituted byte into its InvShiftRows slot of the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < AES_BYTES; i++) begin
        if (4'(i) == dst) begin
          out_q[AES_STATE_W-1-8*i -: 8] <= sub_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_shift_serial.sv
// Directed scoreboard bench for inv_sub_shift_serial with an independent
// GF(2^8)-derived inverse S-box reference.
module tb_inv_sub_shift_serial;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int           errors = 0;
  int           checks = 0;
  int           cycleCount = 0;
  int           acceptLog[$];
  logic [127:0] expQueue[$];
  logic [127:0] lastExpected;
  logic [7:0]   invSbox [256];

  inv_sub_shift_serial dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Count rising edges and log the edge number of every accepted input.
  always @(posedge clk) begin
    cycleCount = cycleCount + 1;
    if (in_valid && in_ready) acceptLog.push_back(cycleCount);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Inverse S-box: undo the affine map, then take the field inverse.
  task automatic buildModel();
    logic [7:0] b;
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      b = rotl8(8'(v), 1) ^ rotl8(8'(v), 3) ^ rotl8(8'(v), 6) ^ 8'h05;
      inv = '0;
      if (b != 8'h00) begin
        for (int cand = 1; cand < 256; cand++) begin
          if (gmul(8'(cand), b) == 8'h01) inv = 8'(cand);
        end
      end
      invSbox[v] = inv;
    end
  endtask

  function automatic logic [127:0] refModel(input logic [127:0] x);
    logic [127:0] y;
    int r;
    int c;
    int d;
    y = '0;
    for (int k = 0; k < 16; k++) begin
      r = k % 4;
      c = k / 4;
      d = r + 4 * ((c + r) % 4);
      y[127-8*d -: 8] = invSbox[x[127-8*k -: 8]];
    end
    return y;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one state when in_ready is up; returns on the negedge after accept.
  task automatic applyStimulus(input string tag, input logic [127:0] x, input bit pushExp);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ready"}, 128'(in_ready), 128'(1));
    in_data = x;
    in_valid = 1'b1;
    if (pushExp) expQueue.push_back(refModel(x));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the negedge right after accept (cycle 1); waits for out_valid.
  task automatic waitOutput(input string tag);
    int n;
    logic [127:0] exp;
    n = 1;
    while (out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, 128'(n), 128'(17));
    exp = (expQueue.size() > 0) ? expQueue.pop_front() : 'x;
    lastExpected = exp;
    checkOutput({tag, "_data"}, out_data, exp);
    checkOutput({tag, "_done_ready"}, 128'(in_ready), 128'(0));
  endtask

  initial begin
    logic [127:0] x;
    int c;
    int lastAcc;

    buildModel();

    // Reset held for two cycles
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_out_data", out_data, 128'h0);
    reset = 1'b0;
    @(negedge clk);

    // Uniform block
    out_ready = 1'b1;
    applyStimulus("uniform", 128'h63636363_63636363_63636363_63636363, 1'b1);
    waitOutput("uniform");
    @(negedge clk);
    checkOutput("uniform_idle_ready", 128'(in_ready), 128'(1));

    // Ordering vector against a fixed known answer
    in_data = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    expQueue.push_back(128'h52f3a338_3009d79e_bf366afb_8140a5d5);
    applyStimulus("order", in_data, 1'b0);
    waitOutput("order");
    @(negedge clk);

    // Backpressure in DONE with input noise
    out_ready = 1'b0;
    applyStimulus("bp", {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    waitOutput("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      checkOutput("bp_hold_data", out_data, lastExpected);
      checkOutput("bp_hold_ready", 128'(in_ready), 128'(0));
    end
    @(negedge clk);
    acceptLog.delete();
    c = cycleCount;
    out_ready = 1'b1;
    x = {$urandom, $urandom, $urandom, $urandom};
    in_data = x;
    in_valid = 1'b1;
    expQueue.push_back(refModel(x));
    @(negedge clk);
    checkOutput("bp_release_ready", 128'(in_ready), 128'(1));
    checkOutput("bp_release_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    lastAcc = (acceptLog.size() > 0) ? acceptLog[acceptLog.size()-1] : -1;
    checkOutput("bp_accept_cycle", 128'(lastAcc), 128'(c + 2));
    waitOutput("bp_next");
    @(negedge clk);

    // Mid-operation reset at RUN cycle 8
    applyStimulus("midrst", {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    checkOutput("midrst_ready", 128'(in_ready), 128'(1));
    checkOutput("midrst_valid", 128'(out_valid), 128'(0));
    checkOutput("midrst_data", out_data, 128'h0);
    reset = 1'b0;
    in_valid = 1'b0;
    applyStimulus("fresh", {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    waitOutput("fresh");
    @(negedge clk);

    // Back-to-back stream at full rate
    acceptLog.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus("b2b", {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      waitOutput("b2b");
      @(negedge clk);
    end
    checkOutput("b2b_accepts", 128'(acceptLog.size()), 128'(4));
    for (int i = 1; i < 4; i++) begin
      lastAcc = (acceptLog.size() > i) ? acceptLog[i] - acceptLog[i-1] : -1;
      checkOutput("b2b_interval", 128'(lastAcc), 128'(18));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
